// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: programs a 16550-style uart_top over Wishbone and streams bytes to it.
//
// After reset the block writes LCR (DLAB set), DL1, DL2 and LCR (DLAB clear), then raises
// init_done. Bytes offered on the s_data/s_valid/s_ready handshake are buffered in a FIFO
// (accepted during init too). When the FIFO holds data the block reads LSR; if THRE is set it
// writes up to BURST bytes to THR, otherwise it backs off for a fixed gap before polling again.
//
// Ports
//   clk         single clock, all logic on posedge
//   wb_rst_i    synchronous active-high reset
//   s_data      byte to transmit
//   s_valid     s_data is valid
//   s_ready     buffer has room; a byte moves when s_valid & s_ready
//   wb_adr_o    Wishbone address
//   wb_dat_o    Wishbone write data (byte placed on lane adr[1:0])
//   wb_dat_i    Wishbone read data (LSR on bits [15:8])
//   wb_we_o     Wishbone write enable
//   wb_stb_o    Wishbone strobe
//   wb_cyc_o    Wishbone cycle
//   wb_sel_o    Wishbone byte-lane select
//   wb_ack_i    Wishbone acknowledge
//   init_done   UART configuration complete
//   level       FIFO occupancy

module uart_tx_feeder #(
  parameter logic [15:0] DIVISOR    = 16'd2,
  parameter logic [7:0]  LCR_VAL    = 8'h1B,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned BURST      = 16
) (
  input  logic                          clk,
  input  logic                          wb_rst_i,
  input  logic [7:0]                    s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [4:0]                    wb_adr_o,
  output logic [31:0]                   wb_dat_o,
  input  logic [31:0]                   wb_dat_i,
  output logic                          wb_we_o,
  output logic                          wb_stb_o,
  output logic                          wb_cyc_o,
  output logic [3:0]                    wb_sel_o,
  input  logic                          wb_ack_i,
  output logic                          init_done,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  localparam logic [LW-1:0] DepthL = LW'(FIFO_DEPTH);
  localparam logic [4:0]    BurstL = 5'(BURST);

  localparam logic [4:0] AdrThr = 5'd0;
  localparam logic [4:0] AdrDl1 = 5'd0;
  localparam logic [4:0] AdrDl2 = 5'd1;
  localparam logic [4:0] AdrLcr = 5'd3;
  localparam logic [4:0] AdrLsr = 5'd5;

  typedef enum logic [2:0] {
    StInitLcrDlab,
    StInitDl1,
    StInitDl2,
    StInitLcr,
    StPoll,
    StWrThr,
    StGap
  } state_e;

  state_e          state_q, state_d;
  logic            cyc_q, cyc_d;
  logic            we_q, we_d;
  logic [4:0]      adr_q, adr_d;
  logic [3:0]      sel_q, sel_d;
  logic [31:0]     dat_q, dat_d;
  logic            init_done_q, init_done_d;
  logic            ready_q, ready_d;
  logic [LW-1:0]   level_q, level_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [4:0]      burst_q, burst_d;
  logic [2:0]      gap_q, gap_d;

  logic [7:0]      mem_q [FIFO_DEPTH];

  logic            push;
  logic            pop;
  logic            acked;
  logic            launch;
  logic [4:0]      req_adr;
  logic            req_we;
  logic [7:0]      req_byte;
  logic [LW-1:0]   lvl_after_pop;

  // Only THRE (LSR bit 5 -> bus bit 13) is consumed from the read data.
  logic            unused_dat_i;
  assign unused_dat_i = ^{wb_dat_i[31:14], wb_dat_i[12:0]};

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    sel_d       = sel_q;
    dat_d       = dat_q;
    init_done_d = init_done_q;
    burst_d     = burst_q;
    gap_d       = gap_q;

    launch   = 1'b0;
    req_adr  = 5'd0;
    req_we   = 1'b0;
    req_byte = 8'h00;

    push  = s_valid & ready_q;
    pop   = 1'b0;
    acked = cyc_q & wb_ack_i;

    // Occupancy once the head byte leaves, counting a push landing in the same cycle.
    lvl_after_pop = level_q - LW'(1) + LW'(push);

    // Each bus state issues one transaction: launch while the bus is idle, advance on ack.
    // The ack cycle clears cyc, so the next state's launch always sees one idle cycle first.
    unique case (state_q)
      StInitLcrDlab: begin
        req_adr  = AdrLcr;
        req_we   = 1'b1;
        req_byte = LCR_VAL | 8'h80;
        if (!cyc_q) begin
          launch = 1'b1;
        end else if (wb_ack_i) begin
          state_d = StInitDl1;
        end
      end
      StInitDl1: begin
        req_adr  = AdrDl1;
        req_we   = 1'b1;
        req_byte = DIVISOR[7:0];
        if (!cyc_q) begin
          launch = 1'b1;
        end else if (wb_ack_i) begin
          state_d = StInitDl2;
        end
      end
      StInitDl2: begin
        req_adr  = AdrDl2;
        req_we   = 1'b1;
        req_byte = DIVISOR[15:8];
        if (!cyc_q) begin
          launch = 1'b1;
        end else if (wb_ack_i) begin
          state_d = StInitLcr;
        end
      end
      StInitLcr: begin
        req_adr  = AdrLcr;
        req_we   = 1'b1;
        req_byte = LCR_VAL & 8'h7F;
        if (!cyc_q) begin
          launch = 1'b1;
        end else if (wb_ack_i) begin
          state_d     = StPoll;
          init_done_d = 1'b1;
        end
      end
      StPoll: begin
        req_adr = AdrLsr;
        req_we  = 1'b0;
        if (!cyc_q) begin
          // Nothing to send: stay quiet rather than polling LSR.
          launch = (level_q != '0);
        end else if (wb_ack_i) begin
          if (wb_dat_i[13]) begin
            state_d = StWrThr;
            burst_d = 5'd0;
          end else begin
            state_d = StGap;
            gap_d   = 3'd0;
          end
        end
      end
      StWrThr: begin
        req_adr  = AdrThr;
        req_we   = 1'b1;
        req_byte = mem_q[rd_ptr_q];
        if (!cyc_q) begin
          launch = 1'b1;
        end else if (wb_ack_i) begin
          pop     = 1'b1;
          burst_d = burst_q + 5'd1;
          if (lvl_after_pop == '0 || (burst_q + 5'd1) >= BurstL) begin
            state_d = StGap;
            gap_d   = 3'd0;
          end
        end
      end
      StGap: begin
        gap_d = gap_q + 3'd1;
        if (gap_q == 3'd7) begin
          state_d = StPoll;
        end
      end
      default: begin
        state_d = StInitLcrDlab;
      end
    endcase

    if (launch) begin
      cyc_d = 1'b1;
      we_d  = req_we;
      adr_d = req_adr;
      sel_d = 4'b0001 << req_adr[1:0];
      dat_d = req_we ? ({24'h000000, req_byte} << {req_adr[1:0], 3'b000}) : 32'h0;
    end else if (acked) begin
      cyc_d = 1'b0;
      we_d  = 1'b0;
      adr_d = 5'd0;
      sel_d = 4'd0;
      dat_d = 32'h0;
    end

    level_d  = level_q + LW'(push) - LW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    // Registered so s_ready has no path from s_valid or wb_ack_i.
    ready_d  = (level_d < DepthL);
  end

  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      state_q     <= StInitLcrDlab;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= 5'd0;
      sel_q       <= 4'd0;
      dat_q       <= 32'h0;
      init_done_q <= 1'b0;
      ready_q     <= 1'b0;
      level_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      burst_q     <= 5'd0;
      gap_q       <= 3'd0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      sel_q       <= sel_d;
      dat_q       <= dat_d;
      init_done_q <= init_done_d;
      ready_q     <= ready_d;
      level_q     <= level_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      burst_q     <= burst_d;
      gap_q       <= gap_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !wb_rst_i) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_we_o   = we_q;
  assign wb_adr_o  = adr_q;
  assign wb_sel_o  = sel_q;
  assign wb_dat_o  = dat_q;
  assign init_done = init_done_q;
  assign s_ready   = ready_q;
  assign level     = level_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder. A behavioural Wishbone slave answers with 0-3 wait
// states and a controllable THRE; a reference model (byte queue, occupancy count, expected
// init writes) checks every bus transfer and the handshake.

module tb_uart_tx_feeder;

  localparam int DEPTH = 16;
  localparam int BURST = 16;

  logic        clk = 1'b0;
  logic        wb_rst_i;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [4:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i = 32'h0;
  logic        wb_we_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i = 1'b0;
  logic        init_done;
  logic [4:0]  level;

  always #5 clk = ~clk;

  uart_tx_feeder #(
    .DIVISOR    (16'd2),
    .LCR_VAL    (8'h1B),
    .FIFO_DEPTH (DEPTH),
    .BURST      (BURST)
  ) dut (
    .clk       (clk),
    .wb_rst_i  (wb_rst_i),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_dat_i  (wb_dat_i),
    .wb_we_o   (wb_we_o),
    .wb_stb_o  (wb_stb_o),
    .wb_cyc_o  (wb_cyc_o),
    .wb_sel_o  (wb_sel_o),
    .wb_ack_i  (wb_ack_i),
    .init_done (init_done),
    .level     (level)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0]  exp_q[$];
  logic [4:0]  init_adr[$];
  logic [3:0]  init_sel[$];
  logic [31:0] init_dat[$];
  int          bursts[$];
  int          cur_burst  = 0;
  int          thr_count  = 0;
  int          mdl_level  = 0;
  int          thre_mode  = 1;  // 0: busy, 1: empty, 2: random
  int          wait_cnt   = 0;
  int          last_kind  = 0;  // 1: LSR saw THRE, 2: gap expected before next poll
  int          idle       = 0;
  logic        rst_at_edge = 1'b1;

  logic        p_rst = 1'b1;
  logic        p_cyc = 1'b0;
  logic        p_ack = 1'b0;
  logic [11:0] p_ctl = '0;
  logic [31:0] p_dat = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wishbone slave: random wait states, single-cycle ack.
  always @(negedge clk) begin
    if (wb_ack_i) begin
      wb_ack_i = 1'b0;
      wait_cnt = $urandom_range(0, 3);
    end else if (wb_cyc_o && wb_stb_o && !wb_rst_i) begin
      if (wait_cnt == 0) begin
        wb_ack_i = 1'b1;
        if (!wb_we_o) begin
          logic thre;
          thre = (thre_mode == 1) || (thre_mode == 2 && $urandom_range(0, 3) != 0);
          wb_dat_i = {16'h0, (thre ? 8'h60 : 8'h00), 8'h00};
        end else begin
          wb_dat_i = $urandom;
        end
      end else begin
        wait_cnt--;
      end
    end
  end

  // Bus monitor and reference model update at each active edge.
  always @(posedge clk) begin
    rst_at_edge = wb_rst_i;
    if (wb_rst_i) begin
      mdl_level = 0;
      cur_burst = 0;
      last_kind = 0;
      idle      = 0;
    end else begin
      if (p_cyc && !p_ack && !p_rst) begin
        check("bus_ctl_stable", {20'h0, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o},
              {20'h0, p_ctl});
        check("bus_dat_stable", wb_dat_o, p_dat);
      end
      if (p_cyc && p_ack && !p_rst) check("idle_after_ack", {31'h0, wb_cyc_o}, 32'h0);
      if (wb_cyc_o && !p_cyc && !wb_we_o && last_kind == 2)
        check("poll_gap_ok", {31'h0, idle >= 8}, 32'h1);
      if (s_valid && s_ready) mdl_level++;
      if (wb_cyc_o && wb_ack_i) begin
        if (wb_we_o && !init_done) begin
          init_adr.push_back(wb_adr_o);
          init_sel.push_back(wb_sel_o);
          init_dat.push_back(wb_dat_o);
        end else if (wb_we_o) begin
          logic [7:0] e;
          check("thr_adr_sel", {23'h0, wb_adr_o, wb_sel_o}, {23'h0, 5'd0, 4'b0001});
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          check("thr_byte", {24'h0, wb_dat_o[7:0]}, {24'h0, e});
          thr_count++;
          mdl_level--;
          cur_burst++;
          check("burst_limit", {31'h0, cur_burst <= BURST}, 32'h1);
          last_kind = 2;
        end else begin
          check("lsr_adr_sel", {23'h0, wb_adr_o, wb_sel_o}, {23'h0, 5'd5, 4'b0010});
          if (cur_burst > 0) bursts.push_back(cur_burst);
          cur_burst = 0;
          last_kind = wb_dat_i[13] ? 1 : 2;
        end
        idle = 0;
      end
      if (!wb_cyc_o) idle++;
    end
    p_rst = wb_rst_i;
    p_cyc = wb_cyc_o;
    p_ack = wb_ack_i;
    p_ctl = {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o};
    p_dat = wb_dat_o;
  end

  // Occupancy and handshake against the model.
  always @(negedge clk) begin
    if (!rst_at_edge) begin
      check("level", {27'h0, level}, 32'(mdl_level));
      check("s_ready", {31'h0, s_ready}, {31'h0, mdl_level < DEPTH});
    end
  end

  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    s_valid = 1'b1;
    s_data  = b;
    while (!s_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("push_timeout", {31'h0, n < 2000}, 32'h1);
    exp_q.push_back(b);
    @(negedge clk);
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (!init_done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'h0, init_done}, 32'h1);
  endtask

  task automatic wait_thr(input int target);
    int n = 0;
    while (thr_count < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("thr_count", 32'(thr_count), 32'(target));
  endtask

  task automatic check_init_log(input string tag);
    logic [4:0]  ea [4];
    logic [3:0]  es [4];
    logic [31:0] ed [4];
    ea = '{5'd3, 5'd0, 5'd1, 5'd3};
    es = '{4'b1000, 4'b0001, 4'b0010, 4'b1000};
    ed = '{32'h9B000000, 32'h00000002, 32'h00000000, 32'h1B000000};
    check({tag, "_count"}, 32'(init_adr.size()), 32'd4);
    for (int i = 0; i < 4 && i < init_adr.size(); i++) begin
      check({tag, "_adr"}, {27'h0, init_adr[i]}, {27'h0, ea[i]});
      check({tag, "_sel"}, {28'h0, init_sel[i]}, {28'h0, es[i]});
      check({tag, "_dat"}, init_dat[i], ed[i]);
    end
  endtask

  initial begin
    logic [7:0] dir_bytes [8];
    int base;
    int n;
    dir_bytes = '{8'h81, 8'h42, 8'hC3, 8'h24, 8'hA5, 8'h66, 8'hE7, 8'h18};

    wb_rst_i = 1'b1;
    s_valid  = 1'b0;
    s_data   = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_bus", {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, 20'h0}, 32'h0);
    check("rst_dat", wb_dat_o, 32'h0);
    check("rst_flags", {29'h0, init_done, s_ready, 1'b0}, 32'h0);
    check("rst_level", {27'h0, level}, 32'h0);

    // Release; s_ready must be up on the first cycle out of reset.
    wb_rst_i = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'h0, s_ready}, 32'h1);

    // Directed bytes, first accepted while still configuring.
    thre_mode = 1;
    push_byte(dir_bytes[0]);
    check("push_during_init", {26'h0, init_done, level}, {26'h0, 1'b0, 5'd1});
    for (int i = 1; i < 8; i++) push_byte(dir_bytes[i]);
    s_valid = 1'b0;
    wait_init("init_done");
    wait_thr(8);
    repeat (40) @(negedge clk);
    check("directed_thr_total", 32'(thr_count), 32'd8);
    check_init_log("init");

    // Fill to full with THRE busy, hold s_valid while full, then let it drain.
    thre_mode = 0;
    bursts.delete();
    cur_burst = 0;
    base = thr_count;
    for (int i = 0; i < 16; i++) push_byte(8'($urandom));
    s_data = 8'($urandom);
    repeat (6) @(negedge clk);
    check("full_ready_low", {31'h0, s_ready}, 32'h0);
    check("full_level", {27'h0, level}, 32'd16);
    thre_mode = 1;
    push_byte(s_data);
    for (int i = 0; i < 3; i++) push_byte(8'($urandom));
    s_valid = 1'b0;
    wait_thr(base + 20);
    repeat (30) @(negedge clk);
    check("burst_first", bursts.size() > 0 ? 32'(bursts[0]) : 32'hFFFF_FFFF, 32'd16);
    check("burst_second", 32'(cur_burst), 32'd4);
    check("fill_exp_empty", 32'(exp_q.size()), 32'd0);

    // Reset while a THR write is on the bus.
    for (int i = 0; i < 6; i++) push_byte(8'($urandom));
    s_valid = 1'b0;
    n = 0;
    while (!(wb_cyc_o && wb_we_o && init_done) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("thr_seen_before_rst", {31'h0, n < 1000}, 32'h1);
    base = thr_count;
    wb_rst_i = 1'b1;
    exp_q.delete();
    init_adr.delete();
    init_sel.delete();
    init_dat.delete();
    @(negedge clk);
    check("midrst_cyc", {31'h0, wb_cyc_o}, 32'h0);
    check("midrst_level", {27'h0, level}, 32'h0);
    check("midrst_init_done", {31'h0, init_done}, 32'h0);
    @(negedge clk);
    wb_rst_i = 1'b0;
    wait_init("reinit_done");
    repeat (40) @(negedge clk);
    check_init_log("reinit");
    check("discarded_not_sent", 32'(thr_count), 32'(base));

    // Random traffic with random THRE and idle gaps.
    thre_mode = 2;
    base = thr_count;
    for (int i = 0; i < 30; i++) begin
      push_byte(8'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        s_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    s_valid = 1'b0;
    wait_thr(base + 30);
    repeat (20) @(negedge clk);
    check("random_exp_empty", 32'(exp_q.size()), 32'd0);
    check("random_thr_total", 32'(thr_count), 32'(base + 30));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
